riscv_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter that shares the single memory bus between instruction fetch (F stage) and data access (M stage) of the pipelined RISC-V core. It serializes transactions with a three-state FSM, gives data accesses priority with a starvation guard for fetch, and generates the bus stall signals the hazard unit consumes (`o_bus_stallM` drives the hazard unit's bus-stall input). A watchdog aborts transactions the slave never answers.

---
 rtl/riscv_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_riscv_bus_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_bus_arbiter.sv
// Purpose: shares one memory bus between fetch (ibus) and data (dbus) masters, data first with a fetch starvation guard.
// Latency: grant is combinational in the request cycle, o_bus_req follows one cycle later, at least 2 cycles per transaction.
// Backpressure: one transaction at a time; stall outputs hold F/M until their response, and a watchdog aborts a slave that never answers.
module riscv_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_ibus_req,
    input  logic [31:0] i_ibus_addr,
    output logic        o_ibus_gnt,
    output logic        o_ibus_rvalid,
    output logic [31:0] o_ibus_rdata,
    input  logic        i_dbus_req,
    input  logic        i_dbus_we,
    input  logic [3:0]  i_dbus_be,
    input  logic [31:0] i_dbus_addr,
    input  logic [31:0] i_dbus_wdata,
    output logic        o_dbus_gnt,
    output logic        o_dbus_rvalid,
    output logic [31:0] o_dbus_rdata,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    output logic        o_bus_stallM,
    output logic        o_bus_stallF,
    output logic        o_bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;

    state_t          state_q, state_d;
    logic            owner_d_q;     // 1: data master owns the bus, 0: fetch
    logic [SW-1:0]   starve_q;
    logic [WW-1:0]   wd_q;

    logic            grant_d, grant_i;
    logic            complete, abort;
    logic            resp_vld;
    logic [31:0]     resp_dat;

    // Arbitration, completion/abort detection, response routing and next state
    always_comb begin
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        state_d  = state_q;
        if (state_q == IDLE) begin
            if (i_dbus_req && !(i_ibus_req && starve_q == SW'(STARVE_LIMIT)))
                grant_d = 1'b1;
            else if (i_ibus_req)
                grant_i = 1'b1;
            if (grant_d || grant_i)
                state_d = ADDR;
        end else begin
            complete = (state_q == ADDR) ? (i_bus_gnt && i_bus_rvalid) : i_bus_rvalid;
            // A completion in the expiry cycle takes precedence over the abort
            abort    = (wd_q == WW'(TIMEOUT)) && !complete;
            if (complete || abort)
                state_d = IDLE;
            else if (state_q == ADDR && i_bus_gnt)
                state_d = RESP;
        end
        resp_vld      = complete || abort;
        resp_dat      = abort ? 32'h0 : i_bus_rdata;
        o_dbus_gnt    = grant_d;
        o_ibus_gnt    = grant_i;
        o_dbus_rvalid = resp_vld && owner_d_q;
        o_ibus_rvalid = resp_vld && !owner_d_q;
        o_dbus_rdata  = resp_dat;
        o_ibus_rdata  = resp_dat;
        o_bus_err     = abort;
        o_bus_stallM  = (i_dbus_req || (owner_d_q && state_q != IDLE)) && !o_dbus_rvalid;
        o_bus_stallF  = (i_ibus_req || (!owner_d_q && state_q != IDLE)) && !o_ibus_rvalid;
    end

    // State, owner, latched slave request fields, starvation and watchdog counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_d_q   <= 1'b0;
            starve_q    <= '0;
            wd_q        <= '0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_be    <= 4'h0;
            o_bus_addr  <= 32'h0;
            o_bus_wdata <= 32'h0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                owner_d_q   <= 1'b1;
                o_bus_req   <= 1'b1;
                o_bus_we    <= i_dbus_we;
                o_bus_be    <= i_dbus_be;
                o_bus_addr  <= i_dbus_addr;
                o_bus_wdata <= i_dbus_wdata;
                wd_q        <= '0;
            end else if (grant_i) begin
                owner_d_q   <= 1'b0;
                o_bus_req   <= 1'b1;
                o_bus_we    <= 1'b0;
                o_bus_be    <= 4'hF;
                o_bus_addr  <= i_ibus_addr;
                o_bus_wdata <= 32'h0;
                wd_q        <= '0;
            end else if (state_q != IDLE) begin
                if (i_bus_gnt || abort)
                    o_bus_req <= 1'b0;
                if (wd_q != WW'(TIMEOUT))
                    wd_q <= wd_q + 1'b1;
            end
            if (state_q == IDLE) begin
                if (!i_ibus_req || grant_i)
                    starve_q <= '0;
                else if (grant_d && starve_q != SW'(STARVE_LIMIT))
                    starve_q <= starve_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Purpose: directed self-checking bench for riscv_bus_arbiter.
// Latency: inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: slave gnt/rvalid are driven explicitly per cycle by the stimulus.
module tb_riscv_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ibus_req;
    logic [31:0] i_ibus_addr;
    logic        o_ibus_gnt, o_ibus_rvalid;
    logic [31:0] o_ibus_rdata;
    logic        i_dbus_req, i_dbus_we;
    logic [3:0]  i_dbus_be;
    logic [31:0] i_dbus_addr, i_dbus_wdata;
    logic        o_dbus_gnt, o_dbus_rvalid;
    logic [31:0] o_dbus_rdata;
    logic        o_bus_req, o_bus_we;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic        i_bus_gnt, i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        o_bus_stallM, o_bus_stallF, o_bus_err;

    int n_checks = 0;
    int n_errors = 0;

    riscv_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .i_ibus_req(i_ibus_req), .i_ibus_addr(i_ibus_addr),
        .o_ibus_gnt(o_ibus_gnt), .o_ibus_rvalid(o_ibus_rvalid), .o_ibus_rdata(o_ibus_rdata),
        .i_dbus_req(i_dbus_req), .i_dbus_we(i_dbus_we), .i_dbus_be(i_dbus_be),
        .i_dbus_addr(i_dbus_addr), .i_dbus_wdata(i_dbus_wdata),
        .o_dbus_gnt(o_dbus_gnt), .o_dbus_rvalid(o_dbus_rvalid), .o_dbus_rdata(o_dbus_rdata),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_be(o_bus_be),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .o_bus_stallM(o_bus_stallM), .o_bus_stallF(o_bus_stallF), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int          err_cyc;
    logic        got_rv, got_irv;
    logic [31:0] got_rd;
    logic        exp_d;

    initial begin
        rst = 1'b1;
        i_ibus_req = 0; i_ibus_addr = 0;
        i_dbus_req = 0; i_dbus_we = 0; i_dbus_be = 0; i_dbus_addr = 0; i_dbus_wdata = 0;
        i_bus_gnt = 0; i_bus_rvalid = 0; i_bus_rdata = 0;
        tick(); tick();
        #1;
        check("rst_bus_req", o_bus_req, 0);
        check("rst_gnts", {o_ibus_gnt, o_dbus_gnt}, 0);
        check("rst_rvalids", {o_ibus_rvalid, o_dbus_rvalid}, 0);
        check("rst_err", o_bus_err, 0);
        check("rst_stalls", {o_bus_stallM, o_bus_stallF}, 0);
        check("rst_fields", {o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata} == '0, 1);
        tick(); rst = 1'b0;

        // Data read alone: gnt c0, bus_req c1-2, slave gnt c2, rvalid c4
        tick(); i_dbus_req = 1; i_dbus_addr = 32'h100; i_dbus_we = 0; i_dbus_be = 4'hF; #1;
        check("rd_gnt_c0", o_dbus_gnt, 1);
        check("rd_ignt_c0", o_ibus_gnt, 0);
        check("rd_stall_c0", o_bus_stallM, 1);
        check("rd_req_c0", o_bus_req, 0);
        tick(); i_dbus_req = 0; #1;
        check("rd_req_c1", o_bus_req, 1);
        check("rd_addr_c1", o_bus_addr, 32'h100);
        check("rd_stall_c1", o_bus_stallM, 1);
        tick(); i_bus_gnt = 1; #1;
        check("rd_req_c2", o_bus_req, 1);
        check("rd_rv_c2", o_dbus_rvalid, 0);
        tick(); i_bus_gnt = 0; #1;
        check("rd_req_c3", o_bus_req, 0);
        check("rd_stall_c3", o_bus_stallM, 1);
        tick(); i_bus_rvalid = 1; i_bus_rdata = 32'hDEADBEEF; #1;
        check("rd_rv_c4", o_dbus_rvalid, 1);
        check("rd_rdata_c4", o_dbus_rdata, 32'hDEADBEEF);
        check("rd_irv_c4", o_ibus_rvalid, 0);
        check("rd_stall_c4", o_bus_stallM, 0);
        tick(); i_bus_rvalid = 0; #1;
        check("rd_idle_rv", o_dbus_rvalid, 0);

        // Simultaneous requests with a zero-wait slave
        tick();
        i_ibus_req = 1; i_ibus_addr = 32'h200;
        i_dbus_req = 1; i_dbus_we = 1; i_dbus_be = 4'h3; i_dbus_addr = 32'h300; i_dbus_wdata = 32'h12345678;
        #1;
        check("sim_dgnt", o_dbus_gnt, 1);
        check("sim_ignt", o_ibus_gnt, 0);
        check("sim_stallF_c0", o_bus_stallF, 1);
        tick(); i_dbus_req = 0; i_bus_gnt = 1; i_bus_rvalid = 1; i_bus_rdata = 32'h0BADF00D; #1;
        check("sim_wr_fields", {o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata},
              {1'b1, 1'b1, 4'h3, 32'h300, 32'h12345678});
        check("sim_ignt_c1", o_ibus_gnt, 0);
        check("sim_drv_c1", o_dbus_rvalid, 1);
        check("sim_irv_c1", o_ibus_rvalid, 0);
        check("sim_stallF_c1", o_bus_stallF, 1);
        tick(); i_bus_gnt = 0; i_bus_rvalid = 0; #1;
        check("sim_ignt_c2", o_ibus_gnt, 1);
        check("sim_stallF_c2", o_bus_stallF, 1);
        tick(); i_ibus_req = 0; i_bus_gnt = 1; i_bus_rvalid = 1; i_bus_rdata = 32'hCAFEF00D; #1;
        check("sim_if_fields", {o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata},
              {1'b1, 1'b0, 4'hF, 32'h200, 32'h0});
        check("sim_irv_c3", o_ibus_rvalid, 1);
        check("sim_irdata_c3", o_ibus_rdata, 32'hCAFEF00D);
        check("sim_drv_c3", o_dbus_rvalid, 0);
        check("sim_stallF_c3", o_bus_stallF, 0);
        tick(); i_bus_gnt = 0; i_bus_rvalid = 0; i_dbus_we = 0; i_dbus_be = 4'hF; #1;
        check("sim_idle_req", o_bus_req, 0);

        // Starvation: four data grants, then fetch; then data wins again (count cleared)
        i_ibus_addr = 32'h800;
        for (int k = 0; k < 6; k++) begin
            tick();
            i_dbus_req = 1; i_dbus_addr = 32'h500 + 32'(k * 4); i_ibus_req = 1;
            i_bus_gnt = 0; i_bus_rvalid = 0;
            #1;
            exp_d = (k != 4);
            check($sformatf("stv_dgnt_%0d", k), o_dbus_gnt, 32'(exp_d));
            check($sformatf("stv_ignt_%0d", k), o_ibus_gnt, 32'(!exp_d));
            tick();
            if (exp_d) i_dbus_req = 0; else i_ibus_req = 0;
            i_bus_gnt = 1; i_bus_rvalid = 1; i_bus_rdata = 32'(k);
            #1;
            check($sformatf("stv_addr_%0d", k), o_bus_addr, exp_d ? 32'h500 + 32'(k * 4) : 32'h800);
            check($sformatf("stv_rv_%0d", k), {o_dbus_rvalid, o_ibus_rvalid}, exp_d ? 2'b10 : 2'b01);
        end
        tick(); i_ibus_req = 0; i_dbus_req = 0; i_bus_gnt = 0; i_bus_rvalid = 0; #1;
        check("stv_drain", {o_ibus_gnt, o_dbus_gnt}, 0);

        // Watchdog: slave never answers, abort 255 cycles after entering ADDR
        tick(); i_dbus_req = 1; i_dbus_addr = 32'h400; i_bus_rdata = 32'hFFFFFFFF; #1;
        check("wd_gnt", o_dbus_gnt, 1);
        err_cyc = 0; got_rv = 0; got_irv = 0; got_rd = 32'h1;
        for (int c = 1; c <= 300; c++) begin
            tick(); i_dbus_req = 0; #1;
            if (c == 255) check("wd_req_held", o_bus_req, 1);
            if (o_bus_err) begin
                err_cyc = c; got_rv = o_dbus_rvalid; got_irv = o_ibus_rvalid; got_rd = o_dbus_rdata;
                break;
            end
        end
        check("wd_err_cycle", err_cyc, 256);
        check("wd_rvalid", got_rv, 1);
        check("wd_irvalid", got_irv, 0);
        check("wd_rdata", got_rd, 0);
        tick(); #1;
        check("wd_after", {o_bus_req, o_bus_err, o_dbus_rvalid}, 0);
        check("wd_stallM", o_bus_stallM, 0);

        // Reset while in RESP: late response ignored
        tick(); i_dbus_req = 1; i_dbus_addr = 32'h600; #1;
        check("rr_gnt", o_dbus_gnt, 1);
        tick(); i_dbus_req = 0; i_bus_gnt = 1; #1;
        check("rr_req", o_bus_req, 1);
        tick(); i_bus_gnt = 0; rst = 1; #1;
        tick(); rst = 0; i_bus_rvalid = 1; i_bus_rdata = 32'h55; #1;
        check("rr_rv", {o_dbus_rvalid, o_ibus_rvalid}, 0);
        check("rr_out", {o_bus_req, o_bus_err, o_bus_stallM, o_bus_stallF}, 0);
        check("rr_fields", {o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata} == '0, 1);
        tick(); i_bus_rvalid = 0; i_ibus_req = 1; i_ibus_addr = 32'h900; #1;
        check("rr_idle_gnt", o_ibus_gnt, 1);
        tick(); i_ibus_req = 0; #1;
        check("rr_new_addr", o_bus_addr, 32'h900);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
